// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  localparam int NUM_PORTS     = 2;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_WR_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef logic port_id_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester ports 0/1 plus the memory-side strobes of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and the memory together form the environment side.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_addr, mem_wdata, mem_write, mem_read
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_addr, mem_wdata, mem_write, mem_read
  );

endinterface

`default_nettype wire

// File: rtl/dmem_rr_pick.sv
// ============================================================================
// Module   : dmem_rr_pick
// Brief    : Two-way request picker. Round-robin when DMEM_ARB_RR_EN is
//            defined, otherwise fixed priority with port 0 highest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_rr_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
`endif
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt_oh,
  output port_id_t             win_id
);

`ifdef DMEM_ARB_RR_EN
  port_id_t ptr;

  // Pointer names the preferred port; it hands preference to the loser.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~win_id;
    end
  end

  always_comb begin
    win_id = 1'b0;
    if (&req) begin
      win_id = ptr;
    end else if (req[1]) begin
      win_id = 1'b1;
    end
  end
`else
  assign win_id = req[1] & ~req[0];
`endif

  assign gnt_oh = (|req) ? port_onehot(win_id) : '0;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Serialises two requesters onto the single-ported data memory.
//            Arbitration mode selected by macro DMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WR_CYCLES = DEF_WR_CYCLES
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int               CNT_W   = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] ACCESS = 2'(ST_ACCESS);
  localparam logic [1:0] RESP   = 2'(ST_RESP);

  logic [1:0]           state;
  port_id_t             owner;
  logic                 we_l;
  logic                 oor_l;
  logic [ADDR_W-1:0]    addr_l;
  logic [DATA_W-1:0]    wdata_l;
  logic [CNT_W-1:0]     wcnt;

  logic                 gnt0, gnt1;
  logic                 rv0, rv1;
  logic                 err0, err1;
  logic [DATA_W-1:0]    rd0, rd1;

  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] pick_oh;
  port_id_t             pick_id;
  logic                 take;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 in_access;
  logic                 access_done;
  logic [DATA_W-1:0]    resp_data;

  assign req_vec = {bus.p1_req, bus.p0_req};
  assign take    = (state == IDLE) && (|req_vec);

  dmem_rr_pick u_pick (
`ifdef DMEM_ARB_RR_EN
    .clk     (clk),
    .reset   (reset),
    .advance (take),
`endif
    .req     (req_vec),
    .gnt_oh  (pick_oh),
    .win_id  (pick_id)
  );

  assign sel_we    = pick_id ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = pick_id ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = pick_id ? bus.p1_wdata : bus.p0_wdata;

  // Reads and out-of-range accesses take one cycle; writes run the counter out.
  assign in_access   = (state == ACCESS);
  assign access_done = in_access && (!we_l || oor_l || (wcnt == '0));
  assign resp_data   = (!we_l && !oor_l) ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      we_l    <= 1'b0;
      oor_l   <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      wcnt    <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rd0     <= '0;
      rd1     <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      rv0  <= 1'b0;
      rv1  <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      rd0  <= '0;
      rd1  <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            state   <= ACCESS;
            owner   <= pick_id;
            we_l    <= sel_we;
            addr_l  <= sel_addr;
            wdata_l <= sel_wdata;
            oor_l   <= (sel_addr >= ADDR_W'(DEPTH));
            wcnt    <= WR_LOAD;
            gnt0    <= pick_oh[0];
            gnt1    <= pick_oh[1];
          end
        end
        ACCESS: begin
          if (access_done) begin
            state <= RESP;
            if (owner) begin
              rv1  <= 1'b1;
              rd1  <= resp_data;
              err1 <= oor_l;
            end else begin
              rv0  <= 1'b1;
              rd0  <= resp_data;
              err0 <= oor_l;
            end
          end else begin
            wcnt <= wcnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read  = in_access && !we_l && !oor_l;
  assign bus.mem_write = in_access &&  we_l && !oor_l;
  assign bus.mem_addr  = in_access ? addr_l  : '0;
  assign bus.mem_wdata = in_access ? wdata_l : '0;

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rvalid = rv0;
  assign bus.p1_rvalid = rv1;
  assign bus.p0_rdata  = rd0;
  assign bus.p1_rdata  = rd1;
  assign bus.p0_err    = err0;
  assign bus.p1_err    = err1;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a 32-word
//            memory model. Expected contention order follows DMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [63:0] mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [63:0] pre_data;

  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  dmem_arbiter #(
    .ADDR_W    (64),
    .DATA_W    (64),
    .DEPTH     (32),
    .WR_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = (bus.mem_addr < 64'd32) ? mem[bus.mem_addr[4:0]] : 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  task automatic run_access(input string tag, input bit port, input bit we,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            output logic [63:0] rdata, output logic err);
    logic got;
    rdata = '0;
    err   = 1'b0;
    drive(port, 1'b1, we, addr, wdata);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = port ? bus.p1_gnt : bus.p0_gnt;
    end
    check({tag, "_gnt"}, 64'(got), 64'd1);
    drive(port, 1'b0, 1'b0, '0, '0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (port ? bus.p1_rvalid : bus.p0_rvalid) begin
        got   = 1'b1;
        rdata = port ? bus.p1_rdata : bus.p0_rdata;
        err   = port ? bus.p1_err   : bus.p0_err;
      end
    end
    check({tag, "_rvalid"}, 64'(got), 64'd1);
    step();
  endtask

  task automatic preload(input logic [4:0] a, input logic [63:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  logic [63:0] rd;
  logic        er;
  logic        got_any;
  int          wr_cnt;
  logic [3:0]  exp_order;
  logic [3:0]  got_order;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    step();
    preload(5'd5,  64'hA5);
    preload(5'd1,  64'h11);
    preload(5'd2,  64'h22);
    preload(5'd31, 64'h31);

    // reset state
    check("rst_p0_gnt",    64'(bus.p0_gnt),    64'd0);
    check("rst_p1_gnt",    64'(bus.p1_gnt),    64'd0);
    check("rst_rvalid",    64'({bus.p0_rvalid, bus.p1_rvalid}), 64'd0);
    check("rst_err",       64'({bus.p0_err, bus.p1_err}),       64'd0);
    check("rst_rdata",     bus.p0_rdata | bus.p1_rdata, 64'd0);
    check("rst_mem_strb",  64'({bus.mem_read, bus.mem_write}), 64'd0);
    check("rst_mem_addr",  bus.mem_addr, 64'd0);
    reset = 1'b0;
    step();

    // single read of word 5
    drive(1'b0, 1'b1, 1'b0, 64'd5, '0);
    step();
    check("rd_p0_gnt",    64'(bus.p0_gnt),   64'd1);
    check("rd_p1_gnt",    64'(bus.p1_gnt),   64'd0);
    check("rd_mem_read",  64'(bus.mem_read), 64'd1);
    check("rd_mem_addr",  bus.mem_addr,      64'd5);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step();
    check("rd_rvalid",    64'(bus.p0_rvalid), 64'd1);
    check("rd_rdata",     bus.p0_rdata,       64'hA5);
    check("rd_err",       64'(bus.p0_err),    64'd0);
    check("rd_mem_read2", 64'(bus.mem_read),  64'd0);
    step();
    check("rd_rvalid_end", 64'(bus.p0_rvalid), 64'd0);
    check("rd_rdata_end",  bus.p0_rdata,       64'd0);

    // p1 write, then read back
    drive(1'b1, 1'b1, 1'b1, 64'd7, 64'h1234);
    step();
    check("wr_p1_gnt",    64'(bus.p1_gnt),    64'd1);
    check("wr_mem_wdata", bus.mem_wdata,      64'h1234);
    check("wr_mem_addr",  bus.mem_addr,       64'd7);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    wr_cnt  = 0;
    got_any = 1'b0;
    rd      = '1;
    for (int i = 0; i < 10 && !got_any; i++) begin
      if (bus.mem_write) wr_cnt++;
      if (bus.p1_rvalid) begin
        got_any = 1'b1;
        rd      = bus.p1_rdata;
        check("wr_ack_err", 64'(bus.p1_err), 64'd0);
        check("wr_ack_strobe", 64'(bus.mem_write), 64'd0);
      end else begin
        step();
      end
    end
    check("wr_ack_seen",  64'(got_any), 64'd1);
    check("wr_cycles",    64'(wr_cnt),  64'd2);
    check("wr_ack_rdata", rd,           64'd0);
    step();
    run_access("rb", 1'b1, 1'b0, 64'd7, '0, rd, er);
    check("rb_rdata", rd,       64'h1234);
    check("rb_err",   64'(er),  64'd0);

    // contention: both held, then p0 drops after three grants
`ifdef DMEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1000;
`endif
    got_order = '0;
    drive(1'b0, 1'b1, 1'b0, 64'd1, '0);
    drive(1'b1, 1'b1, 1'b0, 64'd2, '0);
    for (int g = 0; g < 4; g++) begin
      got_any = 1'b0;
      for (int i = 0; i < 10 && !got_any; i++) begin
        step();
        if (bus.p0_gnt || bus.p1_gnt) begin
          got_any = 1'b1;
          got_order[g] = bus.p1_gnt;
          check("ct_onehot", 64'(bus.p0_gnt & bus.p1_gnt), 64'd0);
        end
      end
      check($sformatf("ct_gnt%0d_seen", g), 64'(got_any), 64'd1);
      if (g == 2) drive(1'b0, 1'b0, 1'b0, '0, '0);
      if (g == 3) drive(1'b1, 1'b0, 1'b0, '0, '0);
    end
    check("ct_order", 64'(got_order), 64'(exp_order));
    step();
    check("ct_p1_rvalid", 64'(bus.p1_rvalid), 64'd1);
    check("ct_p1_rdata",  bus.p1_rdata,       64'h22);
    step();

    // out of range read
    drive(1'b0, 1'b1, 1'b0, 64'd32, '0);
    step();
    check("oor_gnt",   64'(bus.p0_gnt), 64'd1);
    check("oor_strb",  64'({bus.mem_read, bus.mem_write}), 64'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step();
    check("oor_rvalid", 64'(bus.p0_rvalid), 64'd1);
    check("oor_err",    64'(bus.p0_err),    64'd1);
    check("oor_rdata",  bus.p0_rdata,       64'd0);
    step();
    run_access("top", 1'b0, 1'b0, 64'd31, '0, rd, er);
    check("top_rdata", rd,      64'h31);
    check("top_err",   64'(er), 64'd0);
    run_access("hi", 1'b1, 1'b0, 64'h8000_0000_0000_0005, '0, rd, er);
    check("hi_rdata", rd,      64'd0);
    check("hi_err",   64'(er), 64'd1);

    // reset during the first write cycle
    drive(1'b0, 1'b1, 1'b1, 64'd3, 64'hDEAD);
    step();
    check("rmw_strobe", 64'(bus.mem_write), 64'd1);
    reset = 1'b1;
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    check("rmw_write",  64'(bus.mem_write),  64'd0);
    check("rmw_rvalid", 64'(bus.p0_rvalid),  64'd0);
    check("rmw_gnt",    64'(bus.p0_gnt),     64'd0);
    check("rmw_maddr",  bus.mem_addr | bus.mem_wdata, 64'd0);
    got_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      got_any = got_any | bus.p0_rvalid | bus.p1_rvalid;
    end
    check("rmw_no_rvalid", 64'(got_any), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 64'd5, '0);
    step();
    check("rmw_idle_gnt", 64'(bus.p0_gnt), 64'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step();
    step();

    // p1 raised during p0's ACCESS waits for IDLE
    drive(1'b0, 1'b1, 1'b0, 64'd5, '0);
    step();
    check("hold_p0_gnt", 64'(bus.p0_gnt), 64'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 64'd7, '0);
    step();
    check("hold_p0_rvalid", 64'(bus.p0_rvalid), 64'd1);
    check("hold_p0_rdata",  bus.p0_rdata,       64'hA5);
    check("hold_p1_early",  64'(bus.p1_gnt),    64'd0);
    step();
    check("hold_p1_idle",   64'(bus.p1_gnt),    64'd0);
    step();
    check("hold_p1_gnt",    64'(bus.p1_gnt),    64'd1);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    step();
    check("hold_p1_rvalid", 64'(bus.p1_rvalid), 64'd1);
    check("hold_p1_rdata",  bus.p1_rdata,       64'h1234);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port request/grant controller in front of the single-ported 64-bit data memory (32 words) in the nPower pipeline. It shares the memory between the MEM-stage load/store port (port 0) and a secondary port (port 1: debug/loader/DMA). It serialises accesses, drives the memory strobes for the required number of cycles and returns read data or a write acknowledgement per port. It sits between the requesters and the `datamem` instance and owns all of its `address/writedata/MemWrite/MemRead` inputs.

## Interface
- `ADDR_W`, 64, requester and memory address width
- `DATA_W`, 64, data width
- `DEPTH`, 32, number of memory words; addresses ≥ DEPTH are out of range
- `WR_CYCLES`, 2, cycles MemWrite is held per write (≥1)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `p0_req`, `p1_req`  in  1  access request; held until matching `gnt`
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  ADDR_W  word address
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse: request latched
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle pulse: read data / write ack
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data, valid with `rvalid`, else 0
- `p0_err`, `p1_err`  out  1  with `rvalid`: address out of range
- `mem_addr`  out  ADDR_W  to memory `address`
- `mem_wdata`  out  DATA_W  to memory `writedata`
- `mem_write`  out  1  to memory `MemWrite`
- `mem_read`  out  1  to memory `MemRead`
- `mem_rdata`  in  DATA_W  from memory `readdata` (combinational)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any `req` is high, pick the winner, latch its we/addr/wdata and owner id, and go to ACCESS.
  - `gnt` of the winner is registered high for the first ACCESS cycle.
- ACCESS, read: `mem_read`=1 for 1 cycle; `mem_rdata` is captured at the end of that cycle; go to RESP.
- ACCESS, write: `mem_write`=1 for WR_CYCLES cycles, counted by a down-counter; go to RESP when it expires.
- ACCESS, out-of-range address (addr ≥ DEPTH): no strobe; 1 cycle; error flag set; go to RESP.
- RESP: owner's `rvalid`=1 for 1 cycle.
  - `rdata` = captured word for reads, 0 for writes or on error.
  - `err` = range flag.
  - Next state is IDLE.
- `mem_addr`/`mem_wdata` are driven from the latched request during ACCESS and are 0 otherwise.
- Arbitration when both `req` are high in IDLE: see Configuration.
- A `req` seen during ACCESS or RESP is not sampled. It waits for IDLE, and no request is lost.
- A requester drops `req` in the cycle after `gnt`. If `req` is still high in IDLE after its own RESP, that is a new access.

## Timing
- Reset values: state IDLE, all `gnt`/`rvalid`/`err` 0, all `rdata` 0, `mem_*` 0, RR pointer → port 0.
- Read latency: req sampled at edge N → `gnt` in cycle N+1 (ACCESS) → `rvalid` in cycle N+2 → IDLE at N+3. Peak throughput is 1 read per 3 cycles.
- Write: `gnt` in cycle N+1, `mem_write` high cycles N+1..N+WR_CYCLES, ack in cycle N+WR_CYCLES+1.
- `reset` asserted mid-access: at the next edge all strobes drop and the FSM returns to IDLE. No `rvalid` is issued for the aborted access. A write may be partially committed.
- Address comparison is unsigned over the full ADDR_W; `mem_addr` passes all ADDR_W bits.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin.
  - Pointer names the preferred port.
  - After a grant, the pointer moves to the other port.
  - With simultaneous requests, the preferred port wins.
- Not defined: fixed priority; port 0 always wins; no pointer register.

## Structure
- Package `dmem_arb_pkg`:
  - state enum (IDLE, ACCESS, RESP)
  - `NUM_PORTS`=2
  - default DEPTH/WR_CYCLES constants
  - port-id type (1 bit)
- Sub-module `dmem_rr_pick`: 2-way pick from req vector and pointer; outputs one-hot grant and winner id. Its pointer logic is compiled only under `DMEM_ARB_RR_EN`.

## Test plan
- Single read: memory word 5 = 0xA5; p0 reads addr 5 → `p0_gnt` in cycle 1, `mem_read` in cycle 1, `p0_rvalid` with `p0_rdata`=0xA5 in cycle 2, `p0_err`=0.
- Write then read: p1 writes 0x1234 to addr 7 → `mem_write` high exactly WR_CYCLES=2 cycles, ack with `rdata`=0. A following p1 read of addr 7 returns 0x1234.
- Contention: p0 and p1 both request from IDLE, three times back-to-back.
  - With `DMEM_ARB_RR_EN`: grant order is p0, p1, p0.
  - Without it: p0 wins every time while p0 keeps requesting.
- Out of range: p0 reads addr 32 → no `mem_read`/`mem_write`; `p0_rvalid`=1, `p0_err`=1, `p0_rdata`=0 two cycles after the request.
- Reset mid-write: assert `reset` in the 1st `mem_write` cycle → next cycle `mem_write`=0, no `rvalid`, state IDLE, all outputs 0.
- Held request: p1 raises `req` during p0's ACCESS → p1 is granted in the first IDLE-sampled edge after p0's RESP; p0's `rvalid` is unaffected.
